// File: rtl/pic_bus_read_buffer_if.sv
// CPU-side data-bus bundle for the PIC read buffer.
// Master drives strobes and register values; slave returns bus data.
interface pic_bus_read_buffer_if #(
    parameter int IRQ_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int NUM_BYTES = (IRQ_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic                  read;
    logic                  address;
    logic                  write_ocw3;
    logic                  enable_read_register;
    logic                  read_register_isr_or_irr;
    logic                  out_control_logic_data;
    logic [DATA_WIDTH-1:0] control_logic_data;
    logic [IRQ_WIDTH-1:0]  interrupt_mask;
    logic [IRQ_WIDTH-1:0]  interrupt_request_register;
    logic [IRQ_WIDTH-1:0]  in_service_register;
    logic [DATA_WIDTH-1:0] data_bus_out;
    logic                  data_bus_drive;
    logic [IDX_W-1:0]      byte_index;

    modport master (
        output read, address, write_ocw3,
        output enable_read_register, read_register_isr_or_irr,
        output out_control_logic_data, control_logic_data,
        output interrupt_mask, interrupt_request_register,
        output in_service_register,
        input  data_bus_out, data_bus_drive, byte_index
    );

    modport slave (
        input  read, address, write_ocw3,
        input  enable_read_register, read_register_isr_or_irr,
        input  out_control_logic_data, control_logic_data,
        input  interrupt_mask, interrupt_request_register,
        input  in_service_register,
        output data_bus_out, data_bus_drive, byte_index
    );
endinterface

// File: rtl/pic_bus_read_buffer.sv
// PIC data-bus read buffer: snapshots IRR/ISR/IMR/control bytes
// and returns them beat by beat with an auto-advancing pointer.
module pic_bus_read_buffer #(
    parameter int IRQ_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    pic_bus_read_buffer_if.slave   bus
);
    localparam int NB = (IRQ_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int SW = NB * DATA_WIDTH;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_IRR,
        SRC_ISR,
        SRC_IMR,
        SRC_CTRL
    } src_e;

    logic                  sel_q, sel_d;
    logic                  read_q;
    logic                  drv_q;
    src_e                  tag_q, tag_d, src;
    logic [BW-1:0]         idx_q, idx_d, idx_inc;
    logic [SW-1:0]         snap_q, snap_d, snap_sel;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rise, fall;

    assign rise = bus.read & ~read_q;
    assign fall = ~bus.read & read_q;

    always_comb begin
        src      = SRC_IRR;
        snap_sel = SW'(bus.interrupt_request_register);
        if (bus.out_control_logic_data) begin
            src      = SRC_CTRL;
            snap_sel = SW'(bus.control_logic_data);
        end else if (bus.address) begin
            src      = SRC_IMR;
            snap_sel = SW'(bus.interrupt_mask);
        end else if (sel_q) begin
            src      = SRC_ISR;
            snap_sel = SW'(bus.in_service_register);
        end
    end

    always_comb begin
        sel_d   = sel_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        idx_inc = (idx_q == BW'(NB - 1)) ? '0 : idx_q + 1'b1;
        if (rise) begin
            tag_d = src;
            if (src != tag_q) idx_d = '0;
        end else if (fall && tag_q != SRC_CTRL) begin
            idx_d = idx_inc;
        end
        // OCW3 pointer clear wins over both source change and advance
        if (bus.write_ocw3) begin
            idx_d = '0;
            if (bus.enable_read_register)
                sel_d = bus.read_register_isr_or_irr;
        end
        if (rise && idx_d == '0) snap_d = snap_sel;
        dout_d = '0;
        if (bus.read)
            dout_d = snap_d[int'(idx_d) * DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q  <= 1'b0;
            read_q <= 1'b0;
            drv_q  <= 1'b0;
            tag_q  <= SRC_NONE;
            idx_q  <= '0;
            snap_q <= '0;
            dout_q <= '0;
        end else begin
            sel_q  <= sel_d;
            read_q <= bus.read;
            drv_q  <= bus.read;
            tag_q  <= tag_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            dout_q <= dout_d;
        end
    end

    assign bus.data_bus_out   = dout_q;
    assign bus.data_bus_drive = drv_q;
    assign bus.byte_index     = idx_q;
endmodule

// File: tb/tb_pic_bus_read_buffer.sv
// Scoreboard bench for pic_bus_read_buffer, 8/8 and 16/8 builds.
// Stimulus pushes expected beats; a negedge monitor checks them.
module tb_pic_bus_read_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd = 0, addr = 0, ocw = 0, rr = 0, ris = 0, octl = 0;
    logic [7:0]  cdat = '0;
    logic [15:0] imr = '0, irr = '0, isr = '0;
    logic        act16 = 1'b0;

    pic_bus_read_buffer_if #(.IRQ_WIDTH(8),  .DATA_WIDTH(8)) bus8 ();
    pic_bus_read_buffer_if #(.IRQ_WIDTH(16), .DATA_WIDTH(8)) bus16 ();

    assign bus8.read                        = rd;
    assign bus8.address                     = addr;
    assign bus8.write_ocw3                  = ocw;
    assign bus8.enable_read_register        = rr;
    assign bus8.read_register_isr_or_irr    = ris;
    assign bus8.out_control_logic_data      = octl;
    assign bus8.control_logic_data          = cdat;
    assign bus8.interrupt_mask              = imr[7:0];
    assign bus8.interrupt_request_register  = irr[7:0];
    assign bus8.in_service_register         = isr[7:0];

    assign bus16.read                       = rd;
    assign bus16.address                    = addr;
    assign bus16.write_ocw3                 = ocw;
    assign bus16.enable_read_register       = rr;
    assign bus16.read_register_isr_or_irr   = ris;
    assign bus16.out_control_logic_data     = octl;
    assign bus16.control_logic_data         = cdat;
    assign bus16.interrupt_mask             = imr;
    assign bus16.interrupt_request_register = irr;
    assign bus16.in_service_register        = isr;

    pic_bus_read_buffer #(.IRQ_WIDTH(8), .DATA_WIDTH(8)) u8 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus8)
    );

    pic_bus_read_buffer #(.IRQ_WIDTH(16), .DATA_WIDTH(8)) u16 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus16)
    );

    typedef struct {
        logic [7:0] d;
        logic       ix;
        int         cyc;
        int         n;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   vec = 0;
    int   err = 0;
    int   cyc = 0;
    int   hc  = 0;
    logic pd  = 1'b0;

    logic [7:0] m_data;
    logic       m_drv;
    logic       m_idx;
    assign m_data = act16 ? bus16.data_bus_out   : bus8.data_bus_out;
    assign m_drv  = act16 ? bus16.data_bus_drive : bus8.data_bus_drive;
    assign m_idx  = act16 ? bus16.byte_index     : bus8.byte_index;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (m_drv && !pd) begin
            if (q.size() == 0) begin
                chk("unexpected_drive", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                cur = q.pop_front();
                chk("beat_data", 32'(m_data), 32'(cur.d));
                chk("beat_index", 32'(m_idx), 32'(cur.ix));
                chk("drive_latency", 32'(cyc), 32'(cur.cyc));
            end
            hc = 1;
        end else if (m_drv && pd) begin
            chk("data_stable", 32'(m_data), 32'(cur.d));
            hc++;
        end else if (!m_drv && pd) begin
            chk("drive_length", 32'(hc), 32'(cur.n));
            chk("data_idle", 32'(m_data), 32'h0);
        end
        pd = m_drv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ocw(input logic r, input logic s);
        tick();
        ocw = 1; rr = r; ris = s;
        tick();
        ocw = 0; rr = 0; ris = 0;
    endtask

    task automatic do_read(input logic [7:0] d, input logic ix,
                           input int n);
        tick();
        rd = 1;
        q.push_back('{d, ix, cyc + 1, n});
        repeat (n) tick();
        rd = 0;
        repeat (3) tick();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_drive"}, 32'(m_drv), 32'h0);
        chk({nm, "_data"}, 32'(m_data), 32'h0);
        chk({nm, "_index"}, 32'(m_idx), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk_reset("reset8");

        irr = 16'h0020;
        do_ocw(1, 0);
        do_read(8'h20, 0, 2);
        isr = 16'h0081;
        do_ocw(1, 1);
        do_read(8'h81, 0, 1);
        do_ocw(0, 0);
        do_read(8'h81, 0, 1);
        octl = 1; cdat = 8'hC4;
        do_read(8'hC4, 0, 1);
        octl = 0;

        rst_n = 0;
        repeat (2) tick();
        act16 = 1;
        rst_n = 1;
        tick();
        chk_reset("reset16");

        irr = 16'hA55A;
        do_read(8'h5A, 0, 1);
        do_read(8'hA5, 1, 1);
        do_read(8'h5A, 0, 1);
        do_read(8'hA5, 1, 1);
        do_read(8'h5A, 0, 1);
        irr = 16'h1234;
        do_read(8'hA5, 1, 1);

        imr = 16'hF00F; addr = 1;
        do_read(8'h0F, 0, 1);
        addr = 0;
        do_read(8'h34, 0, 1);
        addr = 1;
        do_read(8'h0F, 0, 1);
        addr = 0;
        octl = 1;
        do_read(8'hC4, 0, 2);
        chk("ctrl_index_held", 32'(m_idx), 32'h0);
        octl = 0;
        do_read(8'h34, 0, 1);
        chk("index_after_beat0", 32'(m_idx), 32'h1);

        tick();
        rd = 1;
        q.push_back('{8'h12, 1'b1, cyc + 1, 2});
        repeat (2) tick();
        rst_n = 0;
        tick();
        chk_reset("midread_reset");
        q.push_back('{8'h34, 1'b0, cyc + 1, 2});
        rst_n = 1;
        repeat (2) tick();
        rd = 0;
        repeat (3) tick();

        rd = 1;
        q.push_back('{8'h12, 1'b1, cyc + 1, 1});
        tick();
        rd = 0; ocw = 1; rr = 0; ris = 0;
        tick();
        ocw = 0;
        chk("ocw_at_fall_index", 32'(m_idx), 32'h0);
        repeat (2) tick();
        do_read(8'h34, 0, 1);

        repeat (5) tick();
        chk("pending_expected", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
